// File: rtl/fb_pixel_writer.sv
// Framebuffer write-side sink: sequences one render per frame, clips the renderer's
// pixel stream, buffers it in a small FIFO and issues linear-address writes over valid/ready.
module fb_pixel_writer #(
    parameter int CORDW      = 16,
    parameter int CIDXW      = 4,
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 180,
    parameter int ADDRW      = $clog2(WIDTH*HEIGHT),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame,
    output logic                    render_start,
    input  logic                    render_done,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic [CIDXW-1:0]        cidx,
    input  logic                    drawing,
    output logic                    oe,
    output logic                    mem_we,
    input  logic                    mem_grant,
    output logic [ADDRW-1:0]        mem_addr,
    output logic [CIDXW-1:0]        mem_din,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overflow
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = XW + YW + CIDXW;

    typedef enum logic [1:0] {
        IDLE,
        RENDER,
        DRAIN,
        DONE
    } state_t;

    state_t state_reg;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic              pixel_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_en;
    logic              pop_en;
    logic              out_free;
    logic              drain_ok;
    logic [EW-1:0]     head_entry;
    logic [XW-1:0]     head_x;
    logic [YW-1:0]     head_y;
    logic [CIDXW-1:0]  head_c;
    logic [ADDRW-1:0]  addr_next;

    // Negative coordinates are caught by the sign bit; the unsigned compare handles the far edges.
    assign pixel_ok = drawing
                    && !x[CORDW-1] && !y[CORDW-1]
                    && ($unsigned(x) < CORDW'(WIDTH))
                    && ($unsigned(y) < CORDW'(HEIGHT));

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign oe         = (count_reg < CW'(FIFO_DEPTH - 1));

    assign push_en  = pixel_ok && !fifo_full;
    assign out_free = !mem_we || mem_grant;
    assign pop_en   = out_free && !fifo_empty;

    // Nothing buffered, nothing arriving, and the output request is gone or leaving now.
    assign drain_ok = fifo_empty && !push_en && out_free;

    assign head_entry = fifo_mem[rd_ptr_reg];
    assign head_x     = head_entry[EW-1 -: XW];
    assign head_y     = head_entry[CIDXW +: YW];
    assign head_c     = head_entry[CIDXW-1:0];
    assign addr_next  = ADDRW'(head_y) * ADDRW'(WIDTH) + ADDRW'(head_x);

    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem[wr_ptr_reg] <= {x[XW-1:0], y[YW-1:0], cidx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_en && !pop_en) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push_en && pop_en) begin
                count_reg <= count_reg - 1'b1;
            end
            if (pixel_ok && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output register: the request stays frozen until the memory grants it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (pop_en) begin
            mem_we   <= 1'b1;
            mem_addr <= addr_next;
            mem_din  <= head_c;
        end else if (mem_we && mem_grant) begin
            mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            render_start <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            render_start <= 1'b0;
            frame_done   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame) begin
                        render_start <= 1'b1;
                        busy         <= 1'b1;
                        state_reg    <= RENDER;
                    end
                end
                RENDER: begin
                    if (render_done) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_ok) begin
                        frame_done <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: single pixel, clipping, backpressure,
// frame sequencing, overflow and asynchronous reset during drain.
module tb_fb_pixel_writer;

    logic               clk;
    logic               rst_n;
    logic               frame;
    logic               render_start;
    logic               render_done;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [3:0]         cidx;
    logic               drawing;
    logic               oe;
    logic               mem_we;
    logic               mem_grant;
    logic [15:0]        mem_addr;
    logic [3:0]         mem_din;
    logic               busy;
    logic               frame_done;
    logic               overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  din;
        int          cyc;
    } wr_t;

    wr_t wlog[$];

    fb_pixel_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame        (frame),
        .render_start (render_start),
        .render_done  (render_done),
        .x            (x),
        .y            (y),
        .cidx         (cidx),
        .drawing      (drawing),
        .oe           (oe),
        .mem_we       (mem_we),
        .mem_grant    (mem_grant),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every accepted write, in order, with the cycle it was accepted on.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && mem_we && mem_grant) begin
            wlog.push_back('{addr: mem_addr, din: mem_din, cyc: cyc});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int px, input int py, input int pc);
        x       = 16'(px);
        y       = 16'(py);
        cidx    = 4'(pc);
        drawing = 1'b1;
    endtask

    task automatic nopix();
        drawing = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n, input int base, input int cbase);
        check({tag, "_count"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, (i < wlog.size()) ? 32'(wlog[i].addr) : 32'hFFFF_FFFF, 32'(base + i));
            check({tag, "_din"},  (i < wlog.size()) ? 32'(wlog[i].din)  : 32'hFFFF_FFFF, 32'((cbase + i) & 15));
        end
    endtask

    initial begin
        int next;

        rst_n       = 1'b0;
        frame       = 1'b0;
        render_done = 1'b0;
        x           = '0;
        y           = '0;
        cidx        = '0;
        drawing     = 1'b0;
        mem_grant   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_render_start", 32'(render_start), 0);
        check("rst_mem_we",       32'(mem_we),       0);
        check("rst_mem_addr",     32'(mem_addr),     0);
        check("rst_mem_din",      32'(mem_din),      0);
        check("rst_busy",         32'(busy),         0);
        check("rst_frame_done",   32'(frame_done),   0);
        check("rst_overflow",     32'(overflow),     0);
        check("rst_oe",           32'(oe),           1);
        #3 rst_n = 1'b1;
        step();

        // Single pixel (10,5,7): address 5*320+10 = 1610, two cycles after presentation
        mem_grant = 1'b1;
        wlog.delete();
        pix(10, 5, 7);
        step();
        nopix();
        check("single_we_n1", 32'(mem_we), 0);
        step();
        check("single_we_n2", 32'(mem_we),   1);
        check("single_addr",  32'(mem_addr), 1610);
        check("single_din",   32'(mem_din),  7);
        step();
        check("single_we_n3", 32'(mem_we), 0);
        check("single_count", 32'(wlog.size()), 1);
        $display("[TB] single pixel: %0d write(s)", wlog.size());

        // Clipping: only (319,179) -> 57599 and (0,0) -> 0 survive
        wlog.delete();
        pix(-1, 0, 1);   step();
        pix(320, 0, 2);  step();
        pix(0, 180, 3);  step();
        pix(319, 179, 4); step();
        pix(0, 0, 5);    step();
        nopix();
        repeat (5) step();
        check("clip_count", 32'(wlog.size()), 2);
        check("clip_addr0", (wlog.size() > 0) ? 32'(wlog[0].addr) : 32'hFFFF_FFFF, 57599);
        check("clip_din0",  (wlog.size() > 0) ? 32'(wlog[0].din)  : 32'hFFFF_FFFF, 4);
        check("clip_addr1", (wlog.size() > 1) ? 32'(wlog[1].addr) : 32'hFFFF_FFFF, 0);
        check("clip_din1",  (wlog.size() > 1) ? 32'(wlog[1].din)  : 32'hFFFF_FFFF, 5);
        $display("[TB] clip: %0d write(s)", wlog.size());

        // Backpressure: four pixels fill output register + 3 FIFO slots, then oe falls
        mem_grant = 1'b0;
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            check("bp_oe_high", 32'(oe), 1);
            pix(i, 1, i);
            step();
        end
        nopix();
        check("bp_oe_low", 32'(oe), 0);
        repeat (6) step();
        check("bp_overflow", 32'(overflow), 0);
        check("bp_oe_still_low", 32'(oe), 0);
        check("bp_held_we",   32'(mem_we),   1);
        check("bp_held_addr", 32'(mem_addr), 320);
        mem_grant = 1'b1;
        next = 4;
        for (int k = 0; k < 20; k++) begin
            if (next < 8 && oe) begin
                pix(next, 1, next);
                next++;
            end else begin
                nopix();
            end
            step();
        end
        nopix();
        check_writes("bp", 8, 320, 0);
        for (int i = 1; i < 8; i++) begin
            check("bp_no_gap",
                  (i < wlog.size()) ? 32'(wlog[i].cyc - wlog[i-1].cyc) : 32'hFFFF_FFFF, 1);
        end
        check("bp_overflow_end", 32'(overflow), 0);
        $display("[TB] backpressure: %0d write(s)", wlog.size());

        // Frame sequencing
        mem_grant = 1'b0;
        wlog.delete();
        frame = 1'b1;
        step();
        frame = 1'b0;
        check("seq_render_start", 32'(render_start), 1);
        check("seq_busy",         32'(busy),         1);
        step();
        check("seq_start_pulse", 32'(render_start), 0);
        frame = 1'b1;
        step();
        frame = 1'b0;
        check("seq_no_restart", 32'(render_start), 0);
        step();
        check("seq_no_restart2", 32'(render_start), 0);
        for (int i = 0; i < 3; i++) begin
            pix(i, 3, i);
            step();
        end
        nopix();
        render_done = 1'b1;
        step();
        render_done = 1'b0;
        check("seq_fd_pending", 32'(frame_done), 0);
        repeat (3) step();
        check("seq_fd_stalled", 32'(frame_done), 0);
        check("seq_busy_stall", 32'(busy),       1);
        mem_grant = 1'b1;
        step();
        check("seq_fd_w1", 32'(frame_done), 0);
        step();
        check("seq_fd_w2", 32'(frame_done), 0);
        step();
        check("seq_fd_w3",     32'(frame_done), 1);
        check("seq_we_after",  32'(mem_we),     0);
        step();
        check("seq_fd_pulse", 32'(frame_done), 0);
        check("seq_idle_busy", 32'(busy),      0);
        check_writes("seq", 3, 960, 0);
        $display("[TB] frame sequencing: %0d write(s)", wlog.size());

        // Overflow: six forced pixels, grant low -> 1 in output reg, 4 in FIFO, 1 dropped
        mem_grant = 1'b0;
        wlog.delete();
        for (int i = 0; i < 6; i++) begin
            pix(i, 2, i);
            step();
            if (i == 4) check("ovf_before", 32'(overflow), 0);
        end
        nopix();
        check("ovf_set", 32'(overflow), 1);
        check("ovf_oe",  32'(oe),       0);
        mem_grant = 1'b1;
        repeat (10) step();
        check_writes("ovf", 5, 640, 0);
        check("ovf_sticky", 32'(overflow), 1);
        $display("[TB] overflow: %0d write(s)", wlog.size());

        // Asynchronous reset during DRAIN with pixels pending
        mem_grant = 1'b0;
        frame = 1'b1;
        step();
        frame = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix(i, 4, i);
            step();
        end
        nopix();
        render_done = 1'b1;
        step();
        render_done = 1'b0;
        step();
        check("rd_busy_pre", 32'(busy),   1);
        check("rd_we_pre",   32'(mem_we), 1);
        #3 rst_n = 1'b0;
        #1;
        check("rd_async_we",   32'(mem_we),   0);
        check("rd_async_busy", 32'(busy),     0);
        check("rd_async_oe",   32'(oe),       1);
        check("rd_async_ovf",  32'(overflow), 0);
        mem_grant = 1'b1;
        wlog.delete();
        step();
        step();
        #3 rst_n = 1'b1;
        repeat (10) step();
        check("rd_no_writes", 32'(wlog.size()), 0);
        check("rd_we_post",   32'(mem_we),      0);
        check("rd_busy_post", 32'(busy),        0);
        check("rd_fd_post",   32'(frame_done),  0);
        $display("[TB] reset mid-drain: %0d write(s) after release", wlog.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
